instr_fetch: RTL and testbench

//  Instruction fetch stage directly upstream of the control unit (cu).

---
 rtl/instr_fetch_if.sv | 12 +
 rtl/instr_fetch.sv | 148 ++++++++++++++
 tb/tb_instr_fetch.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_if.sv
// Instruction-memory read port: req/addr from the fetch stage, rvalid/rdata from memory.
interface instr_fetch_if #(
  parameter int ADDR_W = 32
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_rvalid;
  logic [31:0]       imem_rdata;

  modport master (output imem_req, output imem_addr, input imem_rvalid, input imem_rdata);
  modport slave  (input imem_req, input imem_addr, output imem_rvalid, output imem_rdata);
endinterface

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, issues one memory read per fetch_go, presents the word to cu.
// Stops on the all-zero halt word or on a memory timeout; branch redirects may arrive at any time.
module instr_fetch #(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter int                PC_STEP   = 4,
  parameter int                TIMEOUT   = 15,
  parameter logic [31:0]       NOP_INSTR = 32'h0000_0013
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_go,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  instr_fetch_if.master     imem,
  output logic [31:0]       instruction,
  output logic              instr_valid,
  output logic [ADDR_W-1:0] pc_out,
  output logic              halted,
  output logic              fetch_err
);
  localparam int              CNT_W       = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, WAIT, HOLD, HALTED} state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] pc_reg, pc_next;
  logic              req_reg, req_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [31:0]       instr_reg, instr_next;
  logic              valid_reg, valid_next;
  logic [ADDR_W-1:0] pc_out_reg, pc_out_next;
  logic              halted_reg, halted_next;
  logic              err_reg, err_next;
  logic [CNT_W-1:0]  count_reg, count_next;
  logic              pend_reg, pend_next;
  logic [ADDR_W-1:0] pend_pc_reg, pend_pc_next;

  logic [ADDR_W-1:0] redirect_target;
  logic [ADDR_W-1:0] restart_pc;
  logic [CNT_W-1:0]  count_inc;

  always_comb begin
    state_next      = state_reg;
    pc_next         = pc_reg;
    req_next        = req_reg;
    addr_next       = addr_reg;
    instr_next      = instr_reg;
    valid_next      = valid_reg;
    pc_out_next     = pc_out_reg;
    halted_next     = halted_reg;
    err_next        = err_reg;
    count_next      = count_reg;
    pend_next       = pend_reg;
    pend_pc_next    = pend_pc_reg;
    redirect_target = {redirect_pc[ADDR_W-1:2], 2'b00};
    restart_pc      = redirect_valid ? redirect_target : pend_pc_reg;
    count_inc       = count_reg + CNT_W'(1);

    case (state_reg)
      IDLE, HOLD: begin
        if (redirect_valid) pc_next = redirect_target;
        if (fetch_go) begin
          req_next   = 1'b1;
          addr_next  = redirect_valid ? redirect_target : pc_reg;
          valid_next = 1'b0;
          count_next = '0;
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (imem.imem_rvalid) begin
          if (redirect_valid || pend_reg) begin
            // A redirect seen during the read wins: drop the word, refetch at the target.
            pc_next    = restart_pc;
            addr_next  = restart_pc;
            count_next = '0;
            pend_next  = 1'b0;
          end else begin
            instr_next  = imem.imem_rdata;
            pc_out_next = pc_reg;
            valid_next  = 1'b1;
            req_next    = 1'b0;
            if (imem.imem_rdata == 32'h0) begin
              halted_next = 1'b1;
              state_next  = HALTED;
            end else begin
              pc_next    = pc_reg + ADDR_W'(PC_STEP);
              state_next = HOLD;
            end
          end
        end else begin
          if (redirect_valid) begin
            pend_next    = 1'b1;
            pend_pc_next = redirect_target;
          end
          count_next = count_inc;
          if (count_inc == TIMEOUT_CNT) begin
            req_next   = 1'b0;
            err_next   = 1'b1;
            state_next = HALTED;
          end
        end
      end
      HALTED: state_next = HALTED;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      pc_reg      <= RESET_PC;
      req_reg     <= 1'b0;
      addr_reg    <= RESET_PC;
      instr_reg   <= NOP_INSTR;
      valid_reg   <= 1'b0;
      pc_out_reg  <= RESET_PC;
      halted_reg  <= 1'b0;
      err_reg     <= 1'b0;
      count_reg   <= '0;
      pend_reg    <= 1'b0;
      pend_pc_reg <= RESET_PC;
    end else begin
      state_reg   <= state_next;
      pc_reg      <= pc_next;
      req_reg     <= req_next;
      addr_reg    <= addr_next;
      instr_reg   <= instr_next;
      valid_reg   <= valid_next;
      pc_out_reg  <= pc_out_next;
      halted_reg  <= halted_next;
      err_reg     <= err_next;
      count_reg   <= count_next;
      pend_reg    <= pend_next;
      pend_pc_reg <= pend_pc_next;
    end
  end

  assign imem.imem_req  = req_reg;
  assign imem.imem_addr = addr_reg;
  assign instruction    = instr_reg;
  assign instr_valid    = valid_reg;
  assign pc_out         = pc_out_reg;
  assign halted         = halted_reg;
  assign fetch_err      = err_reg;
endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios plus a randomized fetch/redirect mix
// checked against a PC-sequence model.
module tb_instr_fetch;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_go;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] instruction;
  logic        instr_valid;
  logic [31:0] pc_out;
  logic        halted;
  logic        fetch_err;

  int total = 0;
  int bad   = 0;

  instr_fetch_if #(.ADDR_W(32)) bus ();

  instr_fetch #(.ADDR_W(32), .RESET_PC(32'h0), .PC_STEP(4), .TIMEOUT(15), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst(rst), .fetch_go(fetch_go), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .imem(bus), .instruction(instruction), .instr_valid(instr_valid),
    .pc_out(pc_out), .halted(halted), .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; fetch_go = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    bus.imem_rvalid = 1'b0; bus.imem_rdata = '0;
    tick(); tick();
    rst = 1'b0;
    tick();
  endtask

  // Issues fetch_go (optionally with a same-cycle redirect) and answers after lat wait cycles.
  task automatic run_fetch(input int lat, input logic [31:0] word, input bit redir,
                           input logic [31:0] rpc, output logic [31:0] addr_seen,
                           output int req_cycles, output bit stable, output bit valid_go,
                           output bit got_req);
    logic [31:0] first;
    fetch_go = 1'b1; redirect_valid = redir; redirect_pc = rpc;
    tick();
    fetch_go = 1'b0; redirect_valid = 1'b0;
    addr_seen = bus.imem_addr; got_req = bus.imem_req; valid_go = instr_valid;
    req_cycles = 0; stable = 1'b1; first = instruction;
    if (!got_req) return;
    for (int i = 0; i <= lat; i++) begin
      if (bus.imem_req) req_cycles++;
      if (instruction !== first) stable = 1'b0;
      if (i == lat) begin bus.imem_rvalid = 1'b1; bus.imem_rdata = word; end
      tick();
      bus.imem_rvalid = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; fetch_go = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    bus.imem_rvalid = 1'b0; bus.imem_rdata = '0;
    tick();
    total++; if (bus.imem_req !== 1'b0) begin bad++; $display("FAIL reset_req got=%h want=0", bus.imem_req); end
    total++; if (bus.imem_addr !== 32'h0) begin bad++; $display("FAIL reset_addr got=%h want=0", bus.imem_addr); end
    total++; if (instruction !== NOP) begin bad++; $display("FAIL reset_instr got=%h want=%h", instruction, NOP); end
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%h want=0", instr_valid); end
    total++; if (pc_out !== 32'h0) begin bad++; $display("FAIL reset_pc_out got=%h want=0", pc_out); end
    total++; if ({halted, fetch_err} !== 2'b00) begin bad++; $display("FAIL reset_flags got=%b want=00", {halted, fetch_err}); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    logic [31:0] a; int rc; bit st, vg, gr;
    do_reset();
    run_fetch(0, 32'h1111_1111, 1'b0, 32'h0, a, rc, st, vg, gr);
    total++; if (!gr || a !== 32'h0) begin bad++; $display("FAIL basic_addr got=%h req=%0d want=0 req=1", a, gr); end
    total++; if (vg !== 1'b0) begin bad++; $display("FAIL basic_valid_in_wait got=%0d want=0", vg); end
    total++; if (rc !== 1) begin bad++; $display("FAIL basic_req_cycles got=%0d want=1", rc); end
    total++; if (instruction !== 32'h1111_1111 || instr_valid !== 1'b1) begin bad++; $display("FAIL basic_instr got=%h v=%0d want=11111111 v=1", instruction, instr_valid); end
    total++; if (pc_out !== 32'h0 || bus.imem_req !== 1'b0) begin bad++; $display("FAIL basic_pc_out got=%h req=%0d want=0 req=0", pc_out, bus.imem_req); end
    $display("basic: addr=%h instr=%h pc_out=%h", a, instruction, pc_out);
  endtask

  task automatic test_latency();
    logic [31:0] a, w; int rc; bit st, vg, gr;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      w = 32'h1000_0001 + 32'(k);
      run_fetch(2, w, 1'b0, 32'h0, a, rc, st, vg, gr);
      total++; if (a !== 32'(4 * k)) begin bad++; $display("FAIL latency_addr[%0d] got=%h want=%h", k, a, 4 * k); end
      total++; if (rc !== 3) begin bad++; $display("FAIL latency_req_cycles[%0d] got=%0d want=3", k, rc); end
      total++; if (!st) begin bad++; $display("FAIL latency_stable[%0d] got=changed want=stable", k); end
      total++; if (instruction !== w || pc_out !== 32'(4 * k)) begin bad++; $display("FAIL latency_word[%0d] got=%h@%h want=%h@%h", k, instruction, pc_out, w, 4 * k); end
      $display("latency: k=%0d addr=%h req_cycles=%0d instr=%h", k, a, rc, instruction);
    end
  endtask

  task automatic test_halt();
    logic [31:0] a; int rc; bit st, vg, gr;
    do_reset();
    run_fetch(1, 32'h0000_0001, 1'b0, 32'h0, a, rc, st, vg, gr);
    run_fetch(1, 32'h0000_0002, 1'b0, 32'h0, a, rc, st, vg, gr);
    run_fetch(1, 32'h0000_0000, 1'b0, 32'h0, a, rc, st, vg, gr);
    total++; if (a !== 32'h8) begin bad++; $display("FAIL halt_addr got=%h want=8", a); end
    total++; if (halted !== 1'b1 || fetch_err !== 1'b0) begin bad++; $display("FAIL halt_flag got=%0d err=%0d want=1 err=0", halted, fetch_err); end
    total++; if (instruction !== 32'h0 || pc_out !== 32'h8 || instr_valid !== 1'b1) begin bad++; $display("FAIL halt_word got=%h@%h v=%0d want=0@8 v=1", instruction, pc_out, instr_valid); end
    run_fetch(0, 32'h1234_5678, 1'b1, 32'h40, a, rc, st, vg, gr);
    total++; if (gr !== 1'b0) begin bad++; $display("FAIL halt_no_req got=%0d want=0", gr); end
    total++; if (halted !== 1'b1 || pc_out !== 32'h8) begin bad++; $display("FAIL halt_sticky got=%0d@%h want=1@8", halted, pc_out); end
    $display("halt: halted=%0d instr=%h pc_out=%h", halted, instruction, pc_out);
  endtask

  task automatic test_redirect();
    do_reset();
    fetch_go = 1'b1; tick(); fetch_go = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'h103; tick(); redirect_valid = 1'b0;
    tick();
    bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'hAAAA_AAAA; tick(); bus.imem_rvalid = 1'b0;
    total++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h100) begin bad++; $display("FAIL redir_refetch got=req%0d@%h want=req1@100", bus.imem_req, bus.imem_addr); end
    total++; if (instruction !== NOP || instr_valid !== 1'b0) begin bad++; $display("FAIL redir_drop got=%h v=%0d want=%h v=0", instruction, instr_valid, NOP); end
    bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'h2222_2222; tick(); bus.imem_rvalid = 1'b0;
    total++; if (instruction !== 32'h2222_2222 || pc_out !== 32'h100 || instr_valid !== 1'b1) begin bad++; $display("FAIL redir_accept got=%h@%h v=%0d want=22222222@100 v=1", instruction, pc_out, instr_valid); end
    $display("redirect: pending target accepted instr=%h pc_out=%h", instruction, pc_out);
    // redirect arriving with rvalid overrides an older pending one
    fetch_go = 1'b1; tick(); fetch_go = 1'b0;
    total++; if (bus.imem_addr !== 32'h104) begin bad++; $display("FAIL redir_next_addr got=%h want=104", bus.imem_addr); end
    redirect_valid = 1'b1; redirect_pc = 32'h300; tick();
    redirect_pc = 32'h207; bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'hBBBB_BBBB; tick();
    redirect_valid = 1'b0; bus.imem_rvalid = 1'b0;
    total++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h204 || instruction !== 32'h2222_2222) begin bad++; $display("FAIL redir_same_cycle got=req%0d@%h instr=%h want=req1@204 instr=22222222", bus.imem_req, bus.imem_addr, instruction); end
    bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'h4444_4444; tick(); bus.imem_rvalid = 1'b0;
    total++; if (instruction !== 32'h4444_4444 || pc_out !== 32'h204) begin bad++; $display("FAIL redir_same_accept got=%h@%h want=44444444@204", instruction, pc_out); end
    // two redirects while waiting: the newer target is used
    fetch_go = 1'b1; tick(); fetch_go = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'h500; tick();
    redirect_pc = 32'h600; tick(); redirect_valid = 1'b0;
    bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'hCCCC_CCCC; tick();
    bus.imem_rdata = 32'h6666_6666; tick(); bus.imem_rvalid = 1'b0;
    total++; if (instruction !== 32'h6666_6666 || pc_out !== 32'h600) begin bad++; $display("FAIL redir_overwrite got=%h@%h want=66666666@600", instruction, pc_out); end
    $display("redirect: overwrite instr=%h pc_out=%h", instruction, pc_out);
  endtask

  task automatic test_timeout();
    int n;
    do_reset();
    fetch_go = 1'b1; tick(); fetch_go = 1'b0;
    n = 0;
    while (bus.imem_req === 1'b1 && n < 40) begin n++; tick(); end
    total++; if (n !== 15) begin bad++; $display("FAIL timeout_cycles got=%0d want=15", n); end
    total++; if (fetch_err !== 1'b1 || halted !== 1'b0 || bus.imem_req !== 1'b0) begin bad++; $display("FAIL timeout_flags got=err%0d halt%0d req%0d want=err1 halt0 req0", fetch_err, halted, bus.imem_req); end
    fetch_go = 1'b1; tick(); fetch_go = 1'b0;
    total++; if (bus.imem_req !== 1'b0 || fetch_err !== 1'b1) begin bad++; $display("FAIL timeout_terminal got=req%0d err%0d want=req0 err1", bus.imem_req, fetch_err); end
    rst = 1'b1; tick();
    total++; if ({fetch_err, halted, instr_valid, bus.imem_req} !== 4'b0000 || instruction !== NOP || pc_out !== 32'h0 || bus.imem_addr !== 32'h0) begin bad++; $display("FAIL timeout_reset got=%b instr=%h pc_out=%h addr=%h want=0000 %h 0 0", {fetch_err, halted, instr_valid, bus.imem_req}, instruction, pc_out, bus.imem_addr, NOP); end
    rst = 1'b0; tick();
    $display("timeout: wait_cycles=%0d recovered by reset", n);
    // reset in the middle of a read, then a late rvalid
    fetch_go = 1'b1; tick(); fetch_go = 1'b0; tick();
    rst = 1'b1; tick(); rst = 1'b0;
    bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'h5555_5555; tick(); bus.imem_rvalid = 1'b0;
    total++; if (instruction !== NOP || instr_valid !== 1'b0 || bus.imem_req !== 1'b0) begin bad++; $display("FAIL late_rvalid got=%h v=%0d req=%0d want=%h v=0 req=0", instruction, instr_valid, bus.imem_req, NOP); end
  endtask

  task automatic test_wrap();
    logic [31:0] a; int rc; bit st, vg, gr;
    do_reset();
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFE; tick(); redirect_valid = 1'b0;
    run_fetch(1, 32'h3333_3333, 1'b0, 32'h0, a, rc, st, vg, gr);
    total++; if (a !== 32'hFFFF_FFFC || pc_out !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_top got=%h/%h want=fffffffc", a, pc_out); end
    run_fetch(0, 32'h4444_4444, 1'b0, 32'h0, a, rc, st, vg, gr);
    total++; if (a !== 32'h0 || instruction !== 32'h4444_4444) begin bad++; $display("FAIL wrap_zero got=%h instr=%h want=0 instr=44444444", a, instruction); end
    run_fetch(1, 32'h7777_7777, 1'b1, 32'h0000_0ABF, a, rc, st, vg, gr);
    total++; if (a !== 32'h0000_0ABC || pc_out !== 32'h0000_0ABC) begin bad++; $display("FAIL wrap_redir_go got=%h/%h want=abc", a, pc_out); end
    $display("wrap: last addr=%h pc_out=%h", a, pc_out);
  endtask

  task automatic test_random();
    logic [31:0] pc_m, instr_m, tgt, w, a;
    bit valid_m, redir, st, vg, gr;
    int op, lat, rc;
    do_reset();
    pc_m = 32'h0; instr_m = NOP; valid_m = 1'b0;
    for (int it = 0; it < 60; it++) begin
      op = $urandom_range(0, 4);
      if (op == 0) begin
        tgt = $urandom;
        redirect_valid = 1'b1; redirect_pc = tgt; tick(); redirect_valid = 1'b0;
        pc_m = tgt & ~32'h3;
      end else if (op == 1) begin
        bus.imem_rvalid = 1'b1; bus.imem_rdata = $urandom; tick(); bus.imem_rvalid = 1'b0;
        total++; if (instruction !== instr_m || instr_valid !== valid_m) begin bad++; $display("FAIL rand_stray[%0d] got=%h v=%0d want=%h v=%0d", it, instruction, instr_valid, instr_m, valid_m); end
      end else begin
        redir = ($urandom_range(0, 3) == 0);
        tgt = $urandom; lat = $urandom_range(0, 4); w = $urandom | 32'h1;
        if (redir) pc_m = tgt & ~32'h3;
        run_fetch(lat, w, redir, tgt, a, rc, st, vg, gr);
        total++; if (a !== pc_m || rc !== lat + 1) begin bad++; $display("FAIL rand_req[%0d] got=%h cyc=%0d want=%h cyc=%0d", it, a, rc, pc_m, lat + 1); end
        total++; if (instruction !== w || pc_out !== pc_m || instr_valid !== 1'b1) begin bad++; $display("FAIL rand_word[%0d] got=%h@%h v=%0d want=%h@%h v=1", it, instruction, pc_out, instr_valid, w, pc_m); end
        $display("random: it=%0d addr=%h lat=%0d redir=%0d instr=%h", it, a, lat, redir, instruction);
        instr_m = w; valid_m = 1'b1; pc_m = pc_m + 32'd4;
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_latency();
    test_halt();
    test_redirect();
    test_timeout();
    test_wrap();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
